// File: rtl/apple_one_pkg.sv
// Shared loader definitions: FSM encoding and frame constants.
// Also consumed by host-side tooling models.
package apple_one_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN,
    DATA,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h55;
  localparam logic [8:0] LEN_MAX = 9'd256;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte gap timer for the loader.
// Pulses expire when the gap reaches CYCLES idle cycles.
module loader_timeout #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!run || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire = run && !clear
               && (cnt == CW'(CYCLES - 1));

endmodule

// File: rtl/mem_loader.sv
// Serial frame loader: sync, address, length, data, checksum.
// Writes payload bytes to RAM while holding the CPU.
module mem_loader
  import apple_one_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_we,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_dout,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_t state, next;

  logic [15:0] addr;
  logic [8:0]  remaining;
  logic [7:0]  sum;
  logic [7:0]  sum_byte;
  logic        timeout;
  logic        wr;
  logic        ok;
  logic        bad;

  assign sum_byte = sum + rx_data;
  assign cpu_hold = (state != IDLE);

  loader_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk(clk),
    .reset_n(reset_n),
    .run(cpu_hold),
    .clear(rx_valid),
    .expire(timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    wr   = 1'b0;
    ok   = 1'b0;
    bad  = 1'b0;
    if (timeout) begin
      next = IDLE;
      bad  = 1'b1;
    end else if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_data == SYNC_BYTE) next = ADDR_HI;
        end
        ADDR_HI: next = ADDR_LO;
        ADDR_LO: next = LEN;
        LEN:     next = DATA;
        DATA: begin
          wr = 1'b1;
          if (remaining == 9'd1) next = CSUM;
        end
        CSUM: begin
          next = IDLE;
          ok   = (sum_byte == 8'd0);
          bad  = (sum_byte != 8'd0);
        end
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_dout    <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      addr        <= '0;
      remaining   <= '0;
      sum         <= '0;
    end else begin
      mem_we <= wr;
      done   <= ok;
      error  <= bad;
      if (rx_valid) begin
        unique case (state)
          ADDR_HI: begin
            addr[15:8] <= rx_data;
            sum        <= rx_data;
          end
          ADDR_LO: begin
            addr[7:0] <= rx_data;
            sum       <= sum_byte;
          end
          LEN: begin
            remaining <= (rx_data == 8'd0)
                       ? LEN_MAX : {1'b0, rx_data};
            sum       <= sum_byte;
          end
          DATA: begin
            mem_address <= addr;
            mem_dout    <= rx_data;
            addr        <= addr + 16'd1;
            remaining   <= remaining - 9'd1;
            sum         <= sum_byte;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized frame bench for mem_loader.
// Frames are built and predicted from the frame format.
module tb_mem_loader;

  localparam logic [7:0] SYNC = 8'h55;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        mem_we;
  logic [15:0] mem_address;
  logic [7:0]  mem_dout;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_we = 0;
  int exp_done = 0;
  int exp_err = 0;

  mem_loader #(
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .mem_we(mem_we),
    .mem_address(mem_address),
    .mem_dout(mem_dout),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (done)   done_cnt++;
    if (error)  err_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check_totals(input string tag);
    #1;
    check({tag, "_we"},   32'(we_cnt),   32'(exp_we));
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_err"},  32'(err_cnt),  32'(exp_err));
    @(negedge clk);
  endtask

  task automatic noise(input int k);
    logic [7:0] b;
    for (int i = 0; i < k; i++) begin
      do b = 8'($urandom); while (b == SYNC);
      put(b);
      check("noise_hold", 32'(cpu_hold), 32'd0);
      check("noise_we", 32'(mem_we), 32'd0);
    end
  endtask

  task automatic run_frame(input logic [15:0] a,
                           input logic [7:0] d[$],
                           input bit good,
                           input int gmin,
                           input int gmax);
    logic [7:0]  s;
    logic [7:0]  cs;
    logic [7:0]  lb;
    logic [15:0] ea;
    int n;
    n  = d.size();
    lb = n[7:0];
    s  = a[15:8] + a[7:0] + lb;
    foreach (d[i]) s = s + d[i];
    cs = -s;
    if (!good) cs = cs + 8'd1;
    put(SYNC);
    check("hold_sync", 32'(cpu_hold), 32'd1);
    idle($urandom_range(gmax, gmin));
    put(a[15:8]);
    idle($urandom_range(gmax, gmin));
    put(a[7:0]);
    idle($urandom_range(gmax, gmin));
    put(lb);
    check("nowe_hdr", 32'(mem_we), 32'd0);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(gmax, gmin));
      put(d[i]);
      ea = a + 16'(i);
      check("we", 32'(mem_we), 32'd1);
      check("addr", 32'(mem_address), 32'(ea));
      check("dout", 32'(mem_dout), 32'(d[i]));
      check("hold", 32'(cpu_hold), 32'd1);
    end
    idle($urandom_range(gmax, gmin));
    put(cs);
    check("done", 32'(done), 32'(good));
    check("err", 32'(error), 32'(!good));
    check("hold_end", 32'(cpu_hold), 32'd0);
    check("nowe_cs", 32'(mem_we), 32'd0);
    exp_we += n;
    if (good) exp_done++;
    else      exp_err++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int n;

    repeat (3) @(negedge clk);
    #1;
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_dout", 32'(mem_dout), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    q = '{8'hA9, 8'h00, 8'h60};
    run_frame(16'h0280, q, 1'b1, 0, 0);
    run_frame(16'h0280, q, 1'b0, 0, 0);
    check_totals("basic");

    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(16'hFFFE, q, 1'b1, 0, 2);

    q = '{SYNC, SYNC, SYNC};
    run_frame(16'h1000, q, 1'b1, 0, 1);

    q = '{8'h01, 8'h02};
    run_frame(16'h2000, q, 1'b1, TMO - 1, TMO - 1);
    check_totals("edge");

    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
    run_frame(16'h3000, q, 1'b1, 0, 0);
    check_totals("len256");

    put(SYNC);
    put(8'h12);
    put(8'h34);
    n = 0;
    while (!error && n < 3 * TMO) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cyc", 32'(n), 32'(TMO));
    check("tmo_hold", 32'(cpu_hold), 32'd0);
    exp_err++;
    q = '{8'h5A};
    run_frame(16'h4000, q, 1'b1, 0, 0);
    check_totals("tmo");

    put(SYNC);
    put(8'h50);
    put(8'h00);
    put(8'h08);
    put(8'hAA);
    put(8'hBB);
    exp_we += 2;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_we", 32'(mem_we), 32'd0);
    check("mid_hold", 32'(cpu_hold), 32'd0);
    check("mid_addr", 32'(mem_address), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    put(8'hCC);
    put(8'hDD);
    put(8'h00);
    check("post_hold", 32'(cpu_hold), 32'd0);
    noise(3);
    check_totals("rst");
    q = '{8'h77, 8'h88};
    run_frame(16'h6000, q, 1'b1, 0, 0);

    for (int f = 0; f < 20; f++) begin
      noise($urandom_range(2, 0));
      q.delete();
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_frame(16'($urandom), q, 1'($urandom), 0, 3);
    end
    check_totals("rand");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h55, frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum idle gap between bytes inside a frame.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port rx_data, input, 8, received byte, valid when rx_valid=1.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe per byte; no backpressure.
REQ-007 SHALL have port mem_we, output, 1, one-cycle write strobe to system RAM.
REQ-008 SHALL have port mem_address, output, 16, write address.
REQ-009 SHALL have port mem_dout, output, 8, write data.
REQ-010 SHALL have port cpu_hold, output, 1, high while a frame is in progress; the CPU clock enable is gated by it.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when a frame completes with a good checksum.
REQ-012 SHALL have port error, output, 1, one-cycle pulse on a bad checksum or a timeout.

Function
REQ-013 SHALL implement states IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM.
REQ-014 In IDLE, rx_valid with rx_data==SYNC_BYTE SHALL go to ADDR_HI; other bytes SHALL be ignored.
REQ-015 ADDR_HI and ADDR_LO SHALL each capture one byte into the base address, then advance.
REQ-016 LEN SHALL capture the count; LEN=0 SHALL mean 256 bytes; next state is DATA.
REQ-017 In DATA, each rx_valid SHALL produce mem_we=1 exactly one cycle later, with mem_dout=the byte and mem_address=the current address.
REQ-018 After each write the current address SHALL increment modulo 2^16 (FFFF wraps to 0000).
REQ-019 After the last data byte the block SHALL go to CSUM.
REQ-020 Checksum: 8-bit modulo sum of ADDR_HI, ADDR_LO, LEN, all data bytes, and the checksum byte.
- Sum==0: assert done.
- Otherwise: assert error.
- Either way: return to IDLE; the done/error pulse coincides with the return.
REQ-021 Data already written SHALL NOT be reverted on error.
REQ-022 cpu_hold SHALL be 1 in every state except IDLE, and SHALL deassert in the cycle done/error pulses.
REQ-023 Timeout: a gap counter clears on each rx_valid and runs in non-IDLE states.
- Reaching TIMEOUT_CYCLES: pulse error, go to IDLE.
- If rx_valid arrives in the same cycle, the byte SHALL take precedence and the counter SHALL clear.
REQ-024 A SYNC_BYTE value received inside a frame SHALL be treated as ordinary data, never as a restart.
REQ-025 mem_we SHALL never assert outside DATA processing; at most one write per rx_valid.
REQ-026 Throughput: back-to-back rx_valid on consecutive cycles SHALL be accepted without loss.

Reset
REQ-027 reset_n low SHALL asynchronously force state=IDLE and clear all registers: mem_we=0, mem_address=0, mem_dout=0, cpu_hold=0, done=0, error=0, checksum and counters 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no further writes and no done/error pulse.
REQ-029 Release SHALL be synchronous to clk; the first byte is accepted in the first cycle after release.

Structure
REQ-030 State encoding and the default SYNC_BYTE SHALL live in a shared package (apple_one_pkg) for reuse by the host-side tooling models.
REQ-031 The gap timer SHALL be a sub-module, loader_timeout (counter, clear, expire pulse); the remainder stays in one module.

Verification
REQ-032 Frame 55 02 80 03 A9 00 60 CS → writes A9@0280, 00@0281, 60@0282; done one cycle after CS; error=0.
REQ-033 Same frame with CS+1 → all three writes occur; error pulses; done=0.
REQ-034 Frame 55 FF FE 04 with 4 data bytes → writes to FFFE, FFFF, 0000, 0001.
REQ-035 LEN=00 with 256 bytes sent back-to-back at one byte per cycle → 256 writes, done, no drops.
REQ-036 Frame stalls after ADDR_LO for TIMEOUT_CYCLES (set to 16 in the bench) → error at cycle 16; cpu_hold falls; a subsequent 55 starts a new frame.
REQ-037 reset_n asserted after the second data byte → no further mem_we, cpu_hold=0, no done/error; noise bytes before 55 in IDLE are ignored.
